// File: rtl/lcd12864_rx.sv
// LCD12864-style bus receiver: decodes host instruction/data transfers into a local 64-byte DDRAM
// with address counter, display/entry flags, timed Clear fill and busy-flag/data readback.
module lcd12864_rx #(
    parameter logic [7:0]  FILL_CHAR  = 8'h20,
    parameter int unsigned CLR_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] dat,
    output logic [7:0] dat_out,
    output logic       dat_oe,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       disp_on,
    output logic       entry_inc,
    output logic       busy,
    output logic       cmd_stb,
    output logic       data_stb,
    output logic       unsup,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {StIdle, StDecode, StClear} state_e;

    state_e      state_q, state_d;
    logic        en_s1_q, en_s2_q, en_s3_q;
    logic        rs_q, rs_d, rw_q, rw_d;
    logic [7:0]  dat_q, dat_d;
    logic [5:0]  ac_q, ac_d;
    logic        disp_on_q, disp_on_d, entry_inc_q, entry_inc_d, busy_q, busy_d;
    logic        cmd_stb_q, cmd_stb_d, data_stb_q, data_stb_d, unsup_q, unsup_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic [15:0] clr_cnt_q, clr_cnt_d;
    logic [1:0]  hold_q, hold_d;
    logic [7:0]  dat_out_q, dat_out_d;
    logic        dat_oe_q, dat_oe_d;
    logic [7:0]  rd_data_q;

    logic [7:0]  ddram [64];
    logic        mem_we;
    logic [5:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic        en_fall;
    logic [5:0]  ac_step;

    always_comb begin
        state_d     = state_q;
        rs_d        = rs_q;
        rw_d        = rw_q;
        dat_d       = dat_q;
        ac_d        = ac_q;
        disp_on_d   = disp_on_q;
        entry_inc_d = entry_inc_q;
        busy_d      = busy_q;
        cmd_stb_d   = 1'b0;
        data_stb_d  = 1'b0;
        unsup_d     = 1'b0;
        drop_cnt_d  = drop_cnt_q;
        clr_cnt_d   = clr_cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = ac_q;
        mem_wdata   = dat_q;

        // Falls in the first cycles after reset are suppressed by the holdoff counter.
        en_fall = en_s3_q & ~en_s2_q & (hold_q == 2'd0);
        hold_d  = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
        ac_step = entry_inc_q ? ac_q + 6'd1 : ac_q - 6'd1;

        if (en_s2_q) begin
            rs_d  = rs;
            rw_d  = rw;
            dat_d = dat;
        end

        dat_oe_d  = en_s2_q & rw;
        dat_out_d = 8'h00;
        if (dat_oe_d) begin
            dat_out_d = rs ? ddram[ac_q] : {busy_q, 1'b0, ac_q};
        end

        unique case (state_q)
            StIdle: begin
                if (en_fall) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StIdle;
                if (!rw_q && rs_q) begin
                    mem_we     = 1'b1;
                    ac_d       = ac_step;
                    data_stb_d = 1'b1;
                end else if (!rw_q) begin
                    cmd_stb_d = 1'b1;
                    if (dat_q == 8'h01) begin
                        ac_d      = 6'd0;
                        busy_d    = 1'b1;
                        clr_cnt_d = 16'd0;
                        state_d   = StClear;
                    end else if (dat_q[7:1] == 7'b0000001) begin
                        ac_d = 6'd0;
                    end else if (dat_q[7:2] == 6'b000001) begin
                        entry_inc_d = dat_q[1];
                    end else if (dat_q[7:3] == 5'b00001) begin
                        disp_on_d = dat_q[2];
                    end else if (dat_q[7:4] == 4'b0011) begin
                        cmd_stb_d = 1'b1;
                    end else if (dat_q[7:5] == 3'b100) begin
                        // Row bits are swapped relative to the instruction encoding.
                        ac_d = {dat_q[3], dat_q[4], dat_q[2:0], 1'b0};
                    end else begin
                        cmd_stb_d = 1'b0;
                        unsup_d   = 1'b1;
                    end
                end else if (rs_q) begin
                    ac_d = ac_step;
                end
            end
            StClear: begin
                if (clr_cnt_q < 16'd64) begin
                    mem_we    = 1'b1;
                    mem_waddr = clr_cnt_q[5:0];
                    mem_wdata = FILL_CHAR;
                end
                clr_cnt_d = clr_cnt_q + 16'd1;
                if (clr_cnt_q == 16'(CLR_CYCLES - 1)) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
                if (en_fall && !rw_q && drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            en_s1_q     <= 1'b0;
            en_s2_q     <= 1'b0;
            en_s3_q     <= 1'b0;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            dat_q       <= 8'h00;
            ac_q        <= 6'd0;
            disp_on_q   <= 1'b0;
            entry_inc_q <= 1'b1;
            busy_q      <= 1'b0;
            cmd_stb_q   <= 1'b0;
            data_stb_q  <= 1'b0;
            unsup_q     <= 1'b0;
            drop_cnt_q  <= 8'h00;
            clr_cnt_q   <= 16'd0;
            hold_q      <= 2'd3;
            dat_out_q   <= 8'h00;
            dat_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_s1_q     <= en;
            en_s2_q     <= en_s1_q;
            en_s3_q     <= en_s2_q;
            rs_q        <= rs_d;
            rw_q        <= rw_d;
            dat_q       <= dat_d;
            ac_q        <= ac_d;
            disp_on_q   <= disp_on_d;
            entry_inc_q <= entry_inc_d;
            busy_q      <= busy_d;
            cmd_stb_q   <= cmd_stb_d;
            data_stb_q  <= data_stb_d;
            unsup_q     <= unsup_d;
            drop_cnt_q  <= drop_cnt_d;
            clr_cnt_q   <= clr_cnt_d;
            hold_q      <= hold_d;
            dat_out_q   <= dat_out_d;
            dat_oe_q    <= dat_oe_d;
        end
    end

    // DDRAM survives reset; the local read port sees pre-write contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            ddram[mem_waddr] <= mem_wdata;
        end
        rd_data_q <= ddram[rd_addr];
    end

    assign dat_out   = dat_out_q;
    assign dat_oe    = dat_oe_q;
    assign rd_data   = rd_data_q;
    assign disp_on   = disp_on_q;
    assign entry_inc = entry_inc_q;
    assign busy      = busy_q;
    assign cmd_stb   = cmd_stb_q;
    assign data_stb  = data_stb_q;
    assign unsup     = unsup_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_lcd12864_rx.sv
// Directed bench for lcd12864_rx with an abstract model of the LCD register/DDRAM state.
module tb_lcd12864_rx;

    logic       clk, rst, en, rs, rw;
    logic [7:0] dat, dat_out, drop_cnt, rd_data;
    logic       dat_oe, disp_on, entry_inc, busy, cmd_stb, data_stb, unsup;
    logic [5:0] rd_addr;

    lcd12864_rx dut (
        .clk(clk), .rst(rst), .en(en), .rs(rs), .rw(rw), .dat(dat),
        .dat_out(dat_out), .dat_oe(dat_oe), .rd_addr(rd_addr), .rd_data(rd_data),
        .disp_on(disp_on), .entry_inc(entry_inc), .busy(busy), .cmd_stb(cmd_stb),
        .data_stb(data_stb), .unsup(unsup), .drop_cnt(drop_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0, n_fail = 0;
    int cyc = 0, last_stb = 0, fall_cyc = 0, busy_cycles = 0;
    int n_cmd = 0, n_data = 0, n_uns = 0;
    bit settled = 0;
    logic [7:0] last_out;

    // Model state
    int m_ac = 0, m_drop = 0;
    bit m_disp = 0, m_inc = 1, m_busy = 0;
    logic [7:0] m_mem [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        n_cmd  += int'(cmd_stb);
        n_data += int'(data_stb);
        n_uns  += int'(unsup);
        if (cmd_stb | data_stb | unsup) last_stb = cyc;
        if (busy === 1'b1) busy_cycles++;
    end

    // Steady-state compare against the model whenever no transfer is in flight.
    always @(negedge clk) begin
        if (settled) begin
            chk("disp_on", disp_on, m_disp);
            chk("entry_inc", entry_inc, m_inc);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("busy", busy, m_busy);
        end
    end

    task automatic model_xfer(input logic r_s, input logic r_w, input logic [7:0] d,
                              output int ec, output int ed, output int eu);
        ec = 0; ed = 0; eu = 0;
        if (m_busy) begin
            if (!r_w && m_drop < 255) m_drop++;
        end else if (r_w) begin
            if (r_s) m_ac = (m_ac + (m_inc ? 1 : 63)) % 64;
        end else if (r_s) begin
            m_mem[m_ac] = d;
            m_ac = (m_ac + (m_inc ? 1 : 63)) % 64;
            ed = 1;
        end else begin
            ec = 1;
            if (d == 8'h01) begin
                m_ac = 0;
                m_busy = 1;
                for (int i = 0; i < 64; i++) m_mem[i] = 8'h20;
            end else if (d inside {[8'h02:8'h03]}) m_ac = 0;
            else if (d inside {[8'h04:8'h07]}) m_inc = d[1];
            else if (d inside {[8'h08:8'h0F]}) m_disp = d[2];
            else if (d inside {[8'h30:8'h3F]}) m_disp = m_disp;
            else if (d inside {[8'h80:8'h9F]})
                m_ac = ((d[3] ? 2 : 0) + (d[4] ? 1 : 0)) * 16 + (d % 8) * 2;
            else begin
                ec = 0;
                eu = 1;
            end
        end
    endtask

    task automatic bus_xfer(input logic r_s, input logic r_w, input logic [7:0] d,
                            input string tag);
        int c0, d0, u0, ec, ed, eu, lat;
        logic [7:0] exp_out;
        settled = 0;
        c0 = n_cmd; d0 = n_data; u0 = n_uns;
        exp_out = r_s ? m_mem[m_ac] : {m_busy, 1'b0, 6'(m_ac)};
        rs = r_s; rw = r_w; dat = d;
        repeat (2) @(posedge clk);
        #1 en = 1;
        repeat (16) @(posedge clk);
        #1;
        last_out = dat_out;
        if (r_w) begin
            chk({tag, " dat_oe high"}, dat_oe, 1);
            chk({tag, " dat_out"}, dat_out, exp_out);
        end
        en = 0;
        fall_cyc = cyc;
        repeat (8) @(posedge clk);
        #1;
        model_xfer(r_s, r_w, d, ec, ed, eu);
        chk({tag, " cmd_stb count"}, n_cmd - c0, ec);
        chk({tag, " data_stb count"}, n_data - d0, ed);
        chk({tag, " unsup count"}, n_uns - u0, eu);
        if (r_w) chk({tag, " dat_oe low"}, dat_oe, 0);
        if (ec + ed + eu > 0) begin
            lat = last_stb - fall_cyc;
            chk({tag, " strobe latency<=4"}, (lat > 0 && lat <= 4), 1);
        end
        rw = 0;
        settled = !m_busy;
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({tag, " busy released"}, (n < 200), 1);
        @(negedge clk);
        chk({tag, " busy cycles"}, busy_cycles, 64);
        m_busy = 0;
        settled = 1;
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s rd[%0d]", tag, a), rd_data, m_mem[a]);
        end
    endtask

    task automatic rd_one(input int a, input logic [7:0] exp, input string tag);
        rd_addr = 6'(a);
        @(posedge clk);
        @(negedge clk);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
        rst = 1; en = 0; rs = 0; rw = 0; dat = 0; rd_addr = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst disp_on", disp_on, 0);
        chk("rst entry_inc", entry_inc, 1);
        chk("rst busy", busy, 0);
        chk("rst drop_cnt", drop_cnt, 0);
        chk("rst strobes", {cmd_stb, data_stb, unsup}, 0);
        chk("rst dat_oe", dat_oe, 0);
        chk("rst dat_out", dat_out, 0);
        @(posedge clk);
        #1 rst = 0;
        settled = 1;
        repeat (5) @(posedge clk);
        #1;

        // Init sequence ending in Clear
        bus_xfer(0, 0, 8'h30, "fnset");
        bus_xfer(0, 0, 8'h0C, "dispctl");
        bus_xfer(0, 0, 8'h06, "entry");
        busy_cycles = 0;
        bus_xfer(0, 0, 8'h01, "clear");
        chk("disp_on after 0C", disp_on, 1);
        wait_clear("clear");
        sweep("fill");
        rd_one(37, 8'h20, "fill literal");

        // Data write while busy is dropped
        busy_cycles = 0;
        bus_xfer(0, 0, 8'h01, "clear2");
        bus_xfer(1, 0, 8'h77, "busywr");
        wait_clear("clear2");
        chk("drop_cnt literal", drop_cnt, 1);
        sweep("after drop");

        // Row 1 writes
        bus_xfer(0, 0, 8'h90, "addr90");
        bus_xfer(1, 0, 8'h41, "wrA");
        bus_xfer(1, 0, 8'h42, "wrB");
        rd_one(16, 8'h41, "rd16 literal");
        rd_one(17, 8'h42, "rd17 literal");
        bus_xfer(0, 1, 8'h00, "bf1");
        chk("AC=18 literal", last_out, 8'h12);

        // Row 3 fill with wrap
        bus_xfer(0, 0, 8'h98, "addr98");
        for (int i = 0; i < 16; i++) bus_xfer(1, 0, 8'hA0 + 8'(i), "row3");
        sweep("row3");
        rd_one(63, 8'hAF, "rd63 literal");
        bus_xfer(0, 1, 8'h00, "bf2");
        chk("AC wrap 0 literal", last_out, 8'h00);

        // Decrement mode wraps 0 -> 63
        bus_xfer(0, 0, 8'h04, "entrydec");
        bus_xfer(0, 0, 8'h80, "addr80");
        bus_xfer(1, 0, 8'h55, "wr55");
        rd_one(0, 8'h55, "rd0 literal");
        bus_xfer(0, 1, 8'h00, "bf3");
        chk("AC=63 literal", last_out, 8'h3F);

        // Unsupported instruction, then busy-flag read
        bus_xfer(0, 0, 8'h20, "unsup20");
        bus_xfer(0, 1, 8'h00, "bf4");
        chk("bf after unsup literal", last_out, 8'h3F);

        // Data read advances AC
        bus_xfer(0, 0, 8'h06, "entryinc");
        bus_xfer(0, 0, 8'h02, "home");
        bus_xfer(1, 1, 8'h00, "dread");
        chk("data read literal", last_out, 8'h55);
        bus_xfer(0, 1, 8'h00, "bf5");
        chk("AC=1 literal", last_out, 8'h01);

        // Reset during Clear aborts the fill
        bus_xfer(0, 0, 8'h01, "clear3");
        repeat (10) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        m_busy = 0; m_ac = 0; m_disp = 0; m_inc = 1; m_drop = 0;
        @(negedge clk);
        chk("abort busy", busy, 0);
        settled = 1;
        repeat (20) @(posedge clk);
        #1;
        bus_xfer(0, 1, 8'h00, "bf6");
        chk("AC after abort literal", last_out, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
